truth_table_sequencer: RTL and testbench

- Synchronous stimulus and checker stage that sits directly upstream of the lab's combinational table modules (Tabla*/KMap*).
- Drives every one of the 2^N_IN input vectors in order and samples the DUT's single output bit for each vector.
- Compares each sample against a parameterised expected truth table and reports pass/fail, the mismatch count and the first failing index.
- Replaces hand-written `#1` stimulus lists with one reusable hardware sequencer.

---
 rtl/ttseq_pkg.sv | 12 +
 rtl/ttseq_vec_gen.sv | 35 +++
 rtl/truth_table_sequencer.sv | 122 ++++++++++++
 tb/tb_truth_table_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttseq_pkg.sv
// Shared state encoding and sizing constants for the truth-table sequencer.
package ttseq_pkg;
   localparam int MAX_N_IN = 6;
   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } state_t;
endpackage

// File: rtl/ttseq_vec_gen.sv
// Sweep index counter and index-to-vector mapping.
// Define TTSEQ_GRAY_EN to sweep in Gray-code order instead of plain binary.
module ttseq_vec_gen
   import ttseq_pkg::*;
#(
   parameter int N_IN = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            advance,
   output logic [N_IN:0]   index,
   output logic [N_IN-1:0] vec,
   output logic            last
);
   localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'((1 << N_IN) - 1);

   logic [N_IN:0] r_index;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_index <= '0;
      end else if (advance) begin
         r_index <= r_index + 1'b1;
      end
   end

   assign index = r_index;
`ifdef TTSEQ_GRAY_EN
   assign vec   = r_index[N_IN-1:0] ^ (r_index[N_IN-1:0] >> 1);
`else
   assign vec   = r_index[N_IN-1:0];
`endif
   assign last  = (r_index == LAST_IDX);
endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 2^N_IN input vectors into a combinational DUT and checks its output
// against EXPECTED. Vector ordering is selected by TTSEQ_GRAY_EN (see ttseq_vec_gen).
module truth_table_sequencer
   import ttseq_pkg::*;
#(
   parameter int                    N_IN     = 4,
   parameter logic [(2**N_IN)-1:0]  EXPECTED = '0,
   parameter int                    SETTLE   = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [N_IN-1:0] vec_out,
   input  logic            dut_y,
   output logic            busy,
   output logic            step_valid,
   output logic            step_ok,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_err_idx
);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

   state_t                r_state;
   logic [SETTLE_W-1:0]   r_settle;
   logic                  r_busy;
   logic                  r_step_valid;
   logic                  r_done;
   logic                  r_pass;
   logic [N_IN:0]         r_err_count;
   logic [N_IN-1:0]       r_first_err_idx;

   logic                  w_clear;
   logic                  w_advance;
   logic                  w_last;
   logic                  w_match;
   logic [N_IN:0]         w_index;
   logic [N_IN-1:0]       w_vec;

   ttseq_vec_gen #(.N_IN(N_IN)) u_vec_gen (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_clear),
      .advance (w_advance),
      .index   (w_index),
      .vec     (w_vec),
      .last    (w_last)
   );

   assign w_clear   = (r_state == IDLE) && start;
   // The all-ones guard only stops the counter from ever rolling over.
   assign w_advance = (r_state == SAMPLE) && !w_last && (w_index != '1);
   // Lookup by vector, so Gray order checks the table entry actually applied.
   assign w_match   = (dut_y == EXPECTED[w_vec]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_settle        <= '0;
         r_busy          <= 1'b0;
         r_step_valid    <= 1'b0;
         r_done          <= 1'b0;
         r_pass          <= 1'b0;
         r_err_count     <= '0;
         r_first_err_idx <= '0;
      end else begin
         r_step_valid <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state         <= APPLY;
                  r_settle        <= SETTLE_LOAD;
                  r_busy          <= 1'b1;
                  r_pass          <= 1'b0;
                  r_err_count     <= '0;
                  r_first_err_idx <= '0;
               end
            end
            APPLY: begin
               if (r_settle == '0) begin
                  r_state      <= SAMPLE;
                  r_step_valid <= 1'b1;
               end else begin
                  r_settle <= r_settle - 1'b1;
               end
            end
            SAMPLE: begin
               if (!w_match) begin
                  r_err_count <= r_err_count + 1'b1;
                  if (r_err_count == '0) begin
                     r_first_err_idx <= w_vec;
                  end
               end
               if (w_last) begin
                  r_state <= FINISH;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err_count == '0) && w_match;
               end else begin
                  r_state  <= APPLY;
                  r_settle <= SETTLE_LOAD;
               end
            end
            FINISH: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign vec_out       = w_vec;
   assign busy          = r_busy;
   assign step_valid    = r_step_valid;
   assign step_ok       = r_step_valid && w_match;
   assign done          = r_done;
   assign pass          = r_pass;
   assign err_count     = r_err_count;
   assign first_err_idx = r_first_err_idx;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomized sweeps of truth_table_sequencer against a table-level reference model.
module tb_truth_table_sequencer;
   localparam int N_IN         = 4;
   localparam int SETTLE       = 2;
   localparam int N_VEC        = 1 << N_IN;
   localparam logic [N_VEC-1:0] EXPECTED = 16'h6996;
   localparam int SWEEP_CYCLES = N_VEC * (SETTLE + 1) + 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            dut_y;
   logic [N_IN-1:0] vec_out;
   logic            busy, step_valid, step_ok, done, pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_err_idx;

   logic [N_VEC-1:0] dut_table;
   logic [N_VEC-1:0] exp_tab;

   int checks = 0;
   int errors = 0;

   // observations from the last sweep
   int              obs_cycles;
   bit              obs_timeout, obs_busy_drop;
   logic [N_IN-1:0] obs_vecs[$];
   logic            obs_oks[$];
   logic [N_IN:0]   obs_err;
   logic [N_IN-1:0] obs_first;
   logic            obs_pass;

   // reference model results
   logic [N_IN-1:0] exp_vecs[N_VEC];
   logic            exp_oks[N_VEC];
   logic [N_IN:0]   exp_err;
   logic [N_IN-1:0] exp_first;
   logic            exp_pass;

   always #5 clk = ~clk;
   assign dut_y = dut_table[vec_out];

   truth_table_sequencer #(
      .N_IN(N_IN), .EXPECTED(EXPECTED), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .vec_out(vec_out), .dut_y(dut_y),
      .busy(busy), .step_valid(step_valid), .step_ok(step_ok), .done(done),
      .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
   );

   task automatic model_sweep(input logic [N_VEC-1:0] tt);
      int v;
      exp_err   = '0;
      exp_first = '0;
      for (int i = 0; i < N_VEC; i++) begin
`ifdef TTSEQ_GRAY_EN
         v = i ^ (i >> 1);
`else
         v = i;
`endif
         exp_vecs[i] = N_IN'(v);
         exp_oks[i]  = (tt[v] == exp_tab[v]);
         if (!exp_oks[i]) begin
            if (exp_err == 0) exp_first = N_IN'(v);
            exp_err = exp_err + 1'b1;
         end
      end
      exp_pass = (exp_err == 0);
   endtask

   // Pulses start and records everything up to and including the done cycle.
   // restart_at != 0 re-pulses start at that cycle and again in the done cycle.
   task automatic run_sweep(input int restart_at);
      obs_vecs.delete();
      obs_oks.delete();
      obs_busy_drop = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      obs_cycles = 1;
      while (!done && obs_cycles < SWEEP_CYCLES + 20) begin
         if (!busy) obs_busy_drop = 1;
         if (step_valid) begin
            obs_vecs.push_back(vec_out);
            obs_oks.push_back(step_ok);
         end
         start = (restart_at != 0) && (obs_cycles == restart_at);
         @(negedge clk);
         obs_cycles++;
      end
      start       = 1'b0;
      obs_timeout = !done;
      if (!busy) obs_busy_drop = 1;
      obs_err   = err_count;
      obs_first = first_err_idx;
      obs_pass  = pass;
      if (restart_at != 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      dut_table = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({vec_out, busy, step_valid, step_ok, done, pass, err_count, first_err_idx} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got vec=%0h busy=%b sv=%b ok=%b done=%b pass=%b err=%0d first=%0d, want all 0",
                  vec_out, busy, step_valid, step_ok, done, pass, err_count, first_err_idx);
      end
      reset = 1'b0;
      $display("reset: outputs vec=%0h busy=%b done=%b err=%0d", vec_out, busy, done, err_count);
   endtask

   task automatic test_sweeps();
      logic [N_VEC-1:0] tt;
      for (int s = 0; s < 8; s++) begin
         if (s == 0)      tt = exp_tab;
         else if (s == 1) tt = ~exp_tab;
         else             tt = N_VEC'($urandom());
         dut_table = tt;
         model_sweep(tt);
         run_sweep(0);
         checks++;
         if (obs_timeout) begin
            errors++;
            $display("FAIL sweep%0d_timeout: no done within %0d cycles, want done at %0d", s, obs_cycles, SWEEP_CYCLES);
         end
         checks++;
         if (obs_cycles != SWEEP_CYCLES) begin
            errors++;
            $display("FAIL sweep%0d_cycles: got %0d want %0d", s, obs_cycles, SWEEP_CYCLES);
         end
         checks++;
         if (obs_vecs.size() != N_VEC) begin
            errors++;
            $display("FAIL sweep%0d_steps: got %0d strobes want %0d", s, obs_vecs.size(), N_VEC);
         end else begin
            for (int i = 0; i < N_VEC; i++) begin
               checks++;
               if (obs_vecs[i] !== exp_vecs[i] || obs_oks[i] !== exp_oks[i]) begin
                  errors++;
                  $display("FAIL sweep%0d_step%0d: got vec=%0h ok=%b want vec=%0h ok=%b",
                           s, i, obs_vecs[i], obs_oks[i], exp_vecs[i], exp_oks[i]);
               end
            end
         end
         checks++;
         if (obs_err !== exp_err || obs_first !== exp_first || obs_pass !== exp_pass) begin
            errors++;
            $display("FAIL sweep%0d_result: got err=%0d first=%0d pass=%b want err=%0d first=%0d pass=%b",
                     s, obs_err, obs_first, obs_pass, exp_err, exp_first, exp_pass);
         end
         checks++;
         if (obs_busy_drop) begin
            errors++;
            $display("FAIL sweep%0d_busy: got busy low during sweep, want high throughout", s);
         end
         repeat (2) @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_pass) begin
            errors++;
            $display("FAIL sweep%0d_after: got done=%b busy=%b pass=%b want done=0 busy=0 pass=%b",
                     s, done, busy, pass, exp_pass);
         end
         $display("sweep %0d: table=%h cycles=%0d err=%0d first=%0d pass=%b", s, tt, obs_cycles, obs_err, obs_first, obs_pass);
      end
   endtask

   task automatic test_back_to_back();
      bit extra;
      dut_table = N_VEC'($urandom());
      model_sweep(dut_table);
      run_sweep(10);
      checks++;
      if (obs_timeout || obs_cycles != SWEEP_CYCLES) begin
         errors++;
         $display("FAIL b2b_cycles: got %0d (timeout=%b) want %0d", obs_cycles, obs_timeout, SWEEP_CYCLES);
      end
      checks++;
      if (obs_err !== exp_err || obs_first !== exp_first || obs_pass !== exp_pass) begin
         errors++;
         $display("FAIL b2b_result: got err=%0d first=%0d pass=%b want err=%0d first=%0d pass=%b",
                  obs_err, obs_first, obs_pass, exp_err, exp_first, exp_pass);
      end
      extra = 0;
      repeat (SWEEP_CYCLES + 5) begin
         if (done || busy) extra = 1;
         @(negedge clk);
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL b2b_no_restart: got busy/done after done-cycle start, want idle");
      end
      run_sweep(0);
      checks++;
      if (obs_timeout || obs_cycles != SWEEP_CYCLES || obs_err !== exp_err) begin
         errors++;
         $display("FAIL b2b_third_start: got cycles=%0d err=%0d want cycles=%0d err=%0d",
                  obs_cycles, obs_err, SWEEP_CYCLES, exp_err);
      end
      $display("back_to_back: cycles=%0d err=%0d idle_after=%b", obs_cycles, obs_err, !extra);
   endtask

   task automatic test_mid_reset();
      int  guard;
      bit  extra;
      dut_table = ~exp_tab;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (vec_out != N_IN'(5) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 100) begin
         errors++;
         $display("FAIL midreset_reach: vector 5 not reached within %0d cycles, want reached", guard);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({vec_out, busy, step_valid, step_ok, done, pass, err_count, first_err_idx} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got vec=%0h busy=%b sv=%b done=%b err=%0d first=%0d, want all 0",
                  vec_out, busy, step_valid, done, err_count, first_err_idx);
      end
      reset = 1'b0;
      extra = 0;
      repeat (SWEEP_CYCLES + 5) begin
         if (done || busy) extra = 1;
         @(negedge clk);
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL midreset_no_done: got busy/done after reset, want idle");
      end
      dut_table = N_VEC'($urandom());
      model_sweep(dut_table);
      run_sweep(0);
      checks++;
      if (obs_timeout || obs_cycles != SWEEP_CYCLES || obs_err !== exp_err
          || obs_first !== exp_first || obs_pass !== exp_pass) begin
         errors++;
         $display("FAIL midreset_fresh: got cycles=%0d err=%0d first=%0d pass=%b want cycles=%0d err=%0d first=%0d pass=%b",
                  obs_cycles, obs_err, obs_first, obs_pass, SWEEP_CYCLES, exp_err, exp_first, exp_pass);
      end
      $display("mid_reset: fresh sweep cycles=%0d err=%0d pass=%b", obs_cycles, obs_err, obs_pass);
   endtask

   initial begin
      exp_tab = EXPECTED;
      test_reset();
      test_sweeps();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
